// File: rtl/apb_master_multi.sv
// rtl/apb_master_multi.sv - parametrised multi-slave APB master with a valid/ready command port
module apb_master_multi #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SEL_W-1:0]  idx;
  logic              dec_err;
  logic [CNT_W-1:0]  wait_cnt;

  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;

  logic [SEL_W-1:0]  cmd_idx;
  logic              cmd_dec_err;
  logic              timeout;
  logic              done;
  logic              accept;
  logic              resp_err_now;

  // Slave index comes from the top address bits; indices past the last slave are decode errors.
  assign cmd_idx     = cmd_addr[ADDR_W-1 -: SEL_W];
  assign cmd_dec_err = ({1'b0, cmd_idx} >= (SEL_W+1)'(NUM_SLV));

  // Pick out the selected slave's response lines; all other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!dec_err && (idx == SEL_W'(i))) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // The wait counter reaching the limit with the slave still not ready aborts the transfer.
  assign timeout = TO_EN && (state == ACCESS) && !dec_err && !sel_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC));

  assign done      = (state == ACCESS) && (dec_err || sel_ready || timeout);
  assign cmd_ready = PRESETn && ((state == IDLE) || done);
  assign accept    = cmd_valid && cmd_ready;

  // Slave error only counts when the slave completes; timeout and decode errors always count.
  assign resp_err_now = dec_err || timeout || (sel_ready && sel_err);

  // Next-state logic: a new command accepted on done goes straight to SETUP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done) begin
          state_nxt = accept ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the command on accept; address, direction and write data hold between transfers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      idx     <= '0;
      dec_err <= 1'b0;
    end else if (accept) begin
      PADDR   <= cmd_addr;
      PWRITE  <= cmd_write;
      idx     <= cmd_idx;
      dec_err <= cmd_dec_err;
      if (cmd_write) begin
        PWDATA <= cmd_wdata;
      end
    end
  end

  // Wait-state counter: cleared when a transfer enters SETUP, counts ACCESS cycles without ready.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !sel_ready && (wait_cnt != {CNT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Response is registered one edge after done; read data is returned only on a clean read.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_err   <= resp_err_now;
      rsp_rdata <= (!resp_err_now && !PWRITE) ? sel_rdata : '0;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  // APB control: select and enable are suppressed for decode errors and cleared in IDLE.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = (state != IDLE) && !dec_err && (idx == SEL_W'(i));
    end
    PENABLE = (state == ACCESS) && !dec_err;
  end

endmodule

// File: tb/tb_apb_master_multi.sv
// tb/tb_apb_master_multi.sv - self-checking bench for apb_master_multi with a timing reference model
module tb_apb_master_multi;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0] PREADY;
  logic [NS-1:0] PSLVERR;

  int checks = 0;
  int errors = 0;

  // Model of the held APB address/direction/data registers.
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata;

  // Pending burst of commands issued with cmd_valid held continuously.
  bit            b_w    [8];
  logic [AW-1:0] b_a    [8];
  logic [DW-1:0] b_d    [8];
  int            b_wait [8];
  bit            b_serr [8];
  logic [DW-1:0] b_rd   [8];
  int            b_n = 0;

  apb_master_multi #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int wt, input bit se, input logic [DW-1:0] rd);
    b_w[b_n] = w; b_a[b_n] = a; b_d[b_n] = d;
    b_wait[b_n] = wt; b_serr[b_n] = se; b_rd[b_n] = rd;
    b_n++;
  endtask

  // Runs the pending burst cycle by cycle. Expected timing comes from arithmetic:
  // a command accepted at edge A has SETUP in A+1, L ACCESS cycles, response at A+2+L,
  // and the next held command is accepted at edge A+1+L.
  task automatic run_burst();
    int L [8];
    int A [8];
    int R [8];
    int id [8];
    bit dc [8];
    bit er [8];
    logic [DW-1:0] erd [8];
    int last;
    for (int i = 0; i < b_n; i++) begin
      bit tmo;
      logic [AW-1:0] a;
      a     = b_a[i];
      id[i] = int'(a[AW-1:AW-2]);
      dc[i] = (id[i] >= NS);
      tmo   = !dc[i] && (b_wait[i] > TO);
      L[i]  = dc[i] ? 1 : (tmo ? TO + 1 : b_wait[i] + 1);
      A[i]  = (i == 0) ? 0 : A[i-1] + 1 + L[i-1];
      R[i]  = A[i] + 2 + L[i];
      er[i] = dc[i] || tmo || b_serr[i];
      erd[i] = (!er[i] && !b_w[i]) ? b_rd[i] : '0;
    end
    last = R[b_n-1];
    for (int c = 0; c <= last; c++) begin
      int offer;
      int act;
      int rsp;
      int j;
      logic [NS-1:0] e_psel;
      logic e_pen;
      logic e_rdy;
      offer = -1; act = -1; rsp = -1;
      for (int i = 0; i < b_n; i++) begin
        if (offer < 0 && A[i] >= c) offer = i;
        if (c > A[i] && c <= A[i] + 1 + L[i]) act = i;
        if (R[i] == c) rsp = i;
      end
      PREADY  = NS'($urandom);
      PSLVERR = NS'($urandom);
      PRDATA  = (NS*DW)'($urandom);
      if (offer >= 0) begin
        cmd_valid = 1'b1;
        cmd_write = b_w[offer];
        cmd_addr  = b_a[offer];
        cmd_wdata = b_d[offer];
      end else begin
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
      end
      e_psel = '0; e_pen = 1'b0; e_rdy = 1'b1;
      if (act >= 0) begin
        if (c == A[act] + 1) begin
          e_rdy = 1'b0;
        end else begin
          j = c - A[act] - 1;
          e_rdy = (j == L[act]);
          if (!dc[act]) begin
            PREADY[id[act]] = (j > b_wait[act]);
            if (j > b_wait[act]) begin
              PSLVERR[id[act]] = b_serr[act];
              PRDATA[id[act]*DW +: DW] = b_rd[act];
            end
          end
        end
        if (!dc[act]) begin
          e_psel = NS'(1 << id[act]);
          e_pen  = (c != A[act] + 1);
        end
      end
      @(negedge PCLK);
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("psel", PSEL, e_psel);
      chk("penable", PENABLE, e_pen);
      chk("paddr", PADDR, m_paddr);
      chk("pwrite", PWRITE, m_pwrite);
      chk("pwdata", PWDATA, m_pwdata);
      chk("rsp_valid", rsp_valid, (rsp >= 0));
      if (rsp >= 0) begin
        chk("rsp_err", rsp_err, er[rsp]);
        chk("rsp_rdata", rsp_rdata, erd[rsp]);
      end
      @(posedge PCLK); #1;
      if (offer >= 0 && A[offer] == c) begin
        m_paddr  = b_a[offer];
        m_pwrite = b_w[offer];
        if (b_w[offer]) m_pwdata = b_d[offer];
      end
    end
    b_n = 0;
  endtask

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h0AB;
    cmd_wdata = 8'h5A;
    PREADY    = '1;
    PSLVERR   = '0;
    PRDATA    = 24'h123456;
    m_paddr   = '0;
    m_pwrite  = 1'b0;
    m_pwdata  = '0;

    // Reset values.
    repeat (3) @(posedge PCLK);
    #1;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", PSEL, 3'b000);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr", PADDR, 9'h000);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_pwdata", PWDATA, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Zero-wait write to slave 0.
    add_cmd(1'b1, 9'h005, 8'hA5, 0, 1'b0, 8'h00);
    run_burst();
    // Read from slave 1 with two wait states.
    add_cmd(1'b0, 9'h085, 8'h00, 2, 1'b0, 8'h3C);
    run_burst();
    // Back-to-back write then read of slave 2.
    add_cmd(1'b1, 9'h010, 8'h6E, 0, 1'b0, 8'h00);
    add_cmd(1'b0, 9'h100, 8'h00, 1, 1'b0, 8'hC3);
    run_burst();
    // Decode error.
    add_cmd(1'b0, 9'h1A0, 8'h00, 0, 1'b0, 8'h99);
    run_burst();
    // Timeout with slave 0 never ready, then a slave error.
    add_cmd(1'b0, 9'h004, 8'h00, 50, 1'b0, 8'h11);
    run_burst();
    add_cmd(1'b0, 9'h0AA, 8'h00, 1, 1'b1, 8'h22);
    run_burst();
    // Wait count exactly at the limit still completes cleanly.
    add_cmd(1'b0, 9'h120, 8'h00, TO, 1'b0, 8'h4D);
    run_burst();

    // Reset during the ACCESS phase of a read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h085; cmd_wdata = 8'h77;
    PREADY = '0; PSLVERR = '0; PRDATA = 24'hABCDEF;
    @(negedge PCLK);
    chk("rstx_ready_idle", cmd_ready, 1'b1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("rstx_penable", PENABLE, 1'b1);
    chk("rstx_psel", PSEL, 3'b010);
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("rstx_cmd_ready", cmd_ready, 1'b0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("rstx_psel0", PSEL, 3'b000);
    chk("rstx_penable0", PENABLE, 1'b0);
    chk("rstx_paddr0", PADDR, 9'h000);
    chk("rstx_pwrite0", PWRITE, 1'b0);
    chk("rstx_pwdata0", PWDATA, 8'h00);
    chk("rstx_rsp_valid0", rsp_valid, 1'b0);
    chk("rstx_rsp_rdata0", rsp_rdata, 8'h00);
    chk("rstx_rsp_err0", rsp_err, 1'b0);
    PRESETn = 1'b1;
    PREADY  = '1;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      chk("rstx_no_rsp", rsp_valid, 1'b0);
      chk("rstx_idle_psel", PSEL, 3'b000);
    end
    @(posedge PCLK); #1;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
    add_cmd(1'b0, 9'h085, 8'h00, 1, 1'b0, 8'h5C);
    run_burst();

    // Randomized bursts, including decode errors, timeouts and slave errors.
    for (int n = 0; n < 40; n++) begin
      int cnt;
      cnt = $urandom_range(1, 3);
      for (int k = 0; k < cnt; k++) begin
        add_cmd(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 6),
                (($urandom % 4) == 0), DW'($urandom));
      end
      run_burst();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_multi.md
# apb_master_multi

Parametrised APB master bridging a valid/ready command port to an APB bus with up to 16 slaves. It generalises the existing two-slave, 9-bit/8-bit APB master with configurable widths, N-way address decode, per-slave PREADY/PRDATA/PSLVERR muxing, back-to-back transfers, and a wait-state timeout. It sits between the bus-control logic and the peripheral slaves.

## Interface
- ADDR_W, 9, address width (≥ SEL_W+1)
- DATA_W, 8, data width
- NUM_SLV, 2, slave count, 2..16; SEL_W = clog2(NUM_SLV)
- TIMEOUT_CYC, 16, max ACCESS wait cycles before abort; 0 disables the timeout

- PCLK  in  1  clock; all logic on the rising edge
- PRESETn  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at the edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address; slave index = cmd_addr[ADDR_W-1 -: SEL_W]
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  slave error, timeout, or decode error
- PSEL  out  NUM_SLV  one-hot select
- PENABLE  out  1  APB access phase
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  NUM_SLV*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-slave ready
- PSLVERR  in  NUM_SLV  per-slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS; reset state IDLE.
- cmd_ready = PRESETn & (state==IDLE | (state==ACCESS & done)). It is combinational.
- On accept: register PADDR, PWRITE, PWDATA (PWDATA only when cmd_write=1), and the slave index. Next state is SETUP.
- SETUP: PSEL[idx]=1 and PENABLE=0. Next state is always ACCESS.
- ACCESS: PENABLE=1 and PSEL held. The done condition is PREADY[idx]=1, a timeout, or a decode error.
  - On done with a command accepted in the same cycle: next state SETUP (back-to-back).
  - On done with no command accepted: next state IDLE.
  - Otherwise: stay in ACCESS.
- Decode error (idx ≥ NUM_SLV): follows the SETUP/ACCESS timing, but PSEL stays all-zero and PENABLE stays 0. Done is forced in the first ACCESS cycle with rsp_err=1.
- Wait counter: cleared on entry to SETUP; increments in each ACCESS cycle with PREADY[idx]=0. Timeout fires when the counter == TIMEOUT_CYC and PREADY[idx]=0. The transfer is then aborted with rsp_err=1.
- Response is registered the edge after done:
  - rsp_err = PSLVERR[idx] | timeout | decode error.
  - rsp_rdata = PRDATA slice of idx on an error-free read; otherwise 0.
- PSLVERR is sampled only when PREADY[idx]=1. Unselected slaves' PREADY, PRDATA and PSLVERR are ignored.
- PADDR, PWRITE and PWDATA hold their values between transfers. PSEL and PENABLE return to 0 in IDLE.

## Timing
- Reset value of every output is 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err. cmd_ready is 0 while PRESETn=0.
- Accept at edge T gives SETUP in T+1, ACCESS in T+2. With zero wait states, done in T+2 and rsp_valid in T+3.
- Each PREADY-low cycle adds one cycle of latency.
- Back-to-back:
  - New SETUP in the cycle after done; no IDLE cycle is inserted.
  - rsp_valid of the previous command coincides with the new SETUP.
  - Sustained throughput is one transfer per 2 cycles.
- Timeout: with TIMEOUT_CYC=N and PREADY stuck low, ACCESS lasts N+1 cycles. rsp_valid follows one cycle later.
- Reset asserted mid-transfer: at the next edge all outputs return to 0 and the state goes to IDLE. No rsp_valid is emitted for the aborted command.
- cmd inputs are ignored while cmd_ready=0; they need not be held.

## Test plan
- Write, NUM_SLV=3, addr 0x005, data 0xA5, slave 0 PREADY=1 → PSEL=001, PENABLE high one cycle, PADDR=0x005, PWDATA=0xA5, PWRITE=1; rsp_valid at T+3 with err=0, rdata=0.
- Read addr 0x085 (slave 1), slave 1 returns 0x3C after 2 wait states → ACCESS lasts 3 cycles; rsp_valid at T+5 with rdata=0x3C, err=0; PRDATA of slaves 0/2 ignored.
- Back-to-back: write 0x010 then read 0x100 (slave 2), cmd_valid held → SETUP of the second transfer in the cycle after the first done; rsp_valid for the first coincides with that SETUP.
- Decode error: NUM_SLV=3, addr 0x1A0 (idx 3) → PSEL=000 and PENABLE=0 throughout; rsp_valid at T+3 with err=1, rdata=0.
- Timeout TIMEOUT_CYC=4, slave 0 PREADY stuck 0 → 5 ACCESS cycles, then rsp_err=1, rdata=0. A slave returning PREADY=1 with PSLVERR=1 → rsp_err=1, rdata=0.
- Reset: PRESETn=0 in the ACCESS of a read → next edge all outputs 0, state IDLE, no rsp_valid; the next command runs normally.
